// File: rtl/clock_edge_gen.sv
// clock_edge_gen: slow CPU clock level plus one-cycle rise/fall strobes, with run, step and halt control.
// Build option: define CLKGEN_HALT_SYNC_EN to let halt act only at the end of a full period.
module clock_edge_gen #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_i,
    input  logic             step_i,
    input  logic             halt_i,
    input  logic [CNT_W-1:0] half_period_i,
    output logic             cpu_clk_o,
    output logic             rise_o,
    output logic             fall_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             freeze;
    logic             step_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            clk_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            clk_q   <= clk_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
`ifdef CLKGEN_HALT_SYNC_EN
        freeze  = 1'b0;
`else
        freeze  = halt_i;
`endif
        // Steps are only queued in step mode; in free-run they are meaningless.
        step_req = step_i & ~run_i;
        case (state_q)
            ST_IDLE: begin
                if (halt_i) begin
                    pend_d = pend_q | step_req;
                end else if (run_i || step_i || pend_q) begin
                    state_d = ST_HIGH;
                    cnt_d   = half_period_i;
                    pend_d  = 1'b0;
                end
            end
            ST_HIGH: begin
                pend_d = pend_q | step_req;
                if (!freeze) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end else begin
                        state_d = ST_LOW;
                        cnt_d   = half_period_i;
                    end
                end
            end
            ST_LOW: begin
                pend_d = pend_q | step_req;
                if (!freeze) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end else if ((run_i || pend_q) && !halt_i) begin
                        state_d = ST_HIGH;
                        cnt_d   = half_period_i;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes mark state changes only, so a frozen phase never re-issues an edge.
    always_comb begin
        clk_d  = (state_d == ST_HIGH);
        rise_d = (state_d == ST_HIGH) && (state_q != ST_HIGH);
        fall_d = (state_d == ST_LOW) && (state_q == ST_HIGH);
    end

    assign cpu_clk_o = clk_q;
    assign rise_o    = rise_q;
    assign fall_o    = fall_q;
    assign busy_o    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_clock_edge_gen.sv
// Self-checking bench for clock_edge_gen: directed vector table, multi-cycle sequences and a randomized run
// checked against a phase-level reference model.
module tb_clock_edge_gen;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             run = 1'b0;
    logic             step = 1'b0;
    logic             halt = 1'b0;
    logic [CNT_W-1:0] hp = '0;
    logic             cpu_clk, rise, fall, busy;

    int n_pass  = 0;
    int n_total = 0;
    logic [3:0] exp_q[$];

    // Reference model: whether a period is active, current level, cycles left in this half, queued step.
    bit m_active, m_level, m_pend, m_rise, m_fall;
    int m_left;

    typedef struct packed {
        logic       run;
        logic       step;
        logic       halt;
        logic [7:0] hp;
        logic [3:0] exp;   // {cpu_clk, rise, fall, busy}
    } vec_t;

    vec_t vecs[19];

    clock_edge_gen #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run_i        (run),
        .step_i       (step),
        .halt_i       (halt),
        .half_period_i(hp),
        .cpu_clk_o    (cpu_clk),
        .rise_o       (rise),
        .fall_o       (fall),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic void model_reset();
        m_active = 1'b0;
        m_level  = 1'b0;
        m_pend   = 1'b0;
        m_rise   = 1'b0;
        m_fall   = 1'b0;
        m_left   = 0;
    endfunction

    function automatic void model_edge();
        bit old_pend;
        bit frozen;
        bit queued_step;
        old_pend    = m_pend;
        queued_step = step && !run;
        m_rise      = 1'b0;
        m_fall      = 1'b0;
`ifdef CLKGEN_HALT_SYNC_EN
        frozen = 1'b0;
`else
        frozen = halt;
`endif
        if (!m_active) begin
            if (halt) begin
                if (queued_step) m_pend = 1'b1;
            end else if (run || step || m_pend) begin
                m_active = 1'b1;
                m_level  = 1'b1;
                m_rise   = 1'b1;
                m_left   = int'(hp);
                m_pend   = 1'b0;
            end
        end else begin
            if (queued_step) m_pend = 1'b1;
            if (!frozen) begin
                if (m_left > 0) begin
                    m_left--;
                end else if (m_level) begin
                    m_level = 1'b0;
                    m_fall  = 1'b1;
                    m_left  = int'(hp);
                end else if ((run || old_pend) && !halt) begin
                    m_level = 1'b1;
                    m_rise  = 1'b1;
                    m_left  = int'(hp);
                    m_pend  = 1'b0;
                end else begin
                    m_active = 1'b0;
                end
            end
        end
    endfunction

    task automatic tick(input bit use_model);
        logic [3:0] e;
        @(posedge clk);
        model_edge();
        exp_q.push_back({m_level, m_rise, m_fall, m_active});
        #1;
        e = exp_q.pop_front();
        if (use_model) begin
            chk("model_cpu_clk", int'(cpu_clk), int'(e[3]));
            chk("model_rise", int'(rise), int'(e[2]));
            chk("model_fall", int'(fall), int'(e[1]));
            chk("model_busy", int'(busy), int'(e[0]));
        end
        chk("strobe_exclusive", int'(rise & fall), 0);
    endtask

    task automatic do_reset();
        run   = 1'b0;
        step  = 1'b0;
        halt  = 1'b0;
        rst_n = 1'b0;
        model_reset();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_cpu_clk", int'(cpu_clk), 0);
        chk("reset_rise", int'(rise), 0);
        chk("reset_fall", int'(fall), 0);
        chk("reset_busy", int'(busy), 0);
        rst_n = 1'b1;
    endtask

    initial begin
        int first_rise, rises, falls, busy_low, hi, idx, busy_cnt, second_rise;

        vecs[0]  = '{1'b0, 1'b0, 1'b0, 8'd2, 4'b0000};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'd2, 4'b1101};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 8'd2, 4'b1001};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 8'd2, 4'b1001};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'd2, 4'b0011};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 8'd2, 4'b0001};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 8'd2, 4'b0001};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 8'd2, 4'b0000};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 8'd2, 4'b0000};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 8'd0, 4'b1101};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 8'd0, 4'b0011};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 8'd0, 4'b1101};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 8'd0, 4'b0011};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 8'd0, 4'b0000};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 8'd0, 4'b0000};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 8'd0, 4'b0000};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 8'd0, 4'b1101};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 8'd0, 4'b0011};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 8'd0, 4'b0000};

        // Directed table: single step, toggle-every-cycle free run, step recorded under halt.
        do_reset();
        for (int i = 0; i < 19; i++) begin
            run  = vecs[i].run;
            step = vecs[i].step;
            halt = vecs[i].halt;
            hp   = vecs[i].hp;
            tick(1'b0);
            chk($sformatf("vec%0d_cpu_clk", i), int'(cpu_clk), int'(vecs[i].exp[3]));
            chk($sformatf("vec%0d_rise", i), int'(rise), int'(vecs[i].exp[2]));
            chk($sformatf("vec%0d_fall", i), int'(fall), int'(vecs[i].exp[1]));
            chk($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].exp[0]));
        end

        // Free run with half period 3: rise right after release, period 8, never idle.
        do_reset();
        hp = 8'd3;
        run = 1'b1;
        first_rise = -1; rises = 0; falls = 0; busy_low = 0;
        for (int c = 0; c < 32; c++) begin
            tick(1'b1);
            if (rise) begin
                rises++;
                if (first_rise < 0) first_rise = c;
            end
            if (fall) begin
                falls++;
                chk("run_fall_phase", c % 8, 4);
            end
            if (rise) chk("run_rise_phase", c % 8, 0);
            if (!busy) busy_low++;
        end
        chk("run_first_rise", first_rise, 0);
        chk("run_rise_count", rises, 4);
        chk("run_fall_count", falls, 4);
        chk("run_busy_gaps", busy_low, 0);

        // One step plus three extra step pulses: exactly two back-to-back periods.
        do_reset();
        hp = 8'd1;
        rises = 0; busy_cnt = 0; second_rise = -1;
        for (int c = 0; c < 14; c++) begin
            step = (c < 4);
            tick(1'b1);
            if (rise) begin
                rises++;
                if (rises == 2) second_rise = c;
            end
            if (busy) busy_cnt++;
        end
        step = 1'b0;
        chk("step_rise_count", rises, 2);
        chk("step_second_rise", second_rise, 4);
        chk("step_busy_cycles", busy_cnt, 8);
        chk("step_end_idle", int'(busy), 0);

        // Halt raised mid-HIGH with half period 5.
        do_reset();
        hp = 8'd5;
        run = 1'b1;
        repeat (3) tick(1'b1);
        halt = 1'b1;
        hi = 0;
        for (int c = 0; c < 14; c++) begin
            tick(1'b1);
            if (cpu_clk) hi++;
        end
`ifdef CLKGEN_HALT_SYNC_EN
        chk("halt_high_cycles", hi, 3);
        chk("halt_parked_idle", int'(busy), 0);
`else
        chk("halt_high_cycles", hi, 14);
        chk("halt_frozen_busy", int'(busy), 1);
`endif
        halt = 1'b0;
        idx = -1;
        for (int c = 0; c < 10; c++) begin
            tick(1'b1);
`ifdef CLKGEN_HALT_SYNC_EN
            if (idx < 0 && rise) idx = c;
`else
            if (idx < 0 && fall) idx = c;
`endif
        end
`ifdef CLKGEN_HALT_SYNC_EN
        chk("halt_release_rise", idx, 0);
`else
        chk("halt_resume_fall", idx, 3);
`endif
        run = 1'b0;

        // Asynchronous reset mid-HIGH with a step queued.
        do_reset();
        hp = 8'd5;
        step = 1'b1;
        tick(1'b1);
        step = 1'b0;
        tick(1'b1);
        step = 1'b1;
        tick(1'b1);
        step = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_cpu_clk", int'(cpu_clk), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_rise", int'(rise), 0);
        chk("async_rst_fall", int'(fall), 0);
        model_reset();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rises = 0;
        for (int c = 0; c < 6; c++) begin
            tick(1'b1);
            if (rise || busy) rises++;
        end
        chk("async_rst_no_pending", rises, 0);
        run = 1'b1;
        tick(1'b1);
        chk("restart_rise", int'(rise), 1);

        // Randomized traffic against the reference model.
        do_reset();
        hp = 8'd2;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 49) == 0) hp = CNT_W'($urandom_range(0, 6));
            if ($urandom_range(0, 39) == 0) run = ~run;
            if ($urandom_range(0, 29) == 0) halt = ~halt;
            step = ($urandom_range(0, 9) == 0);
            tick(1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
